// File: rtl/demux_18_pkg.sv
// Shared constants for the registered 1-to-8 demultiplexer.
package demux_18_pkg;

    localparam int DEMUX_N = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

endpackage

// File: rtl/demux_18_slot.sv
// One output channel: a holding register plus its valid flag.
module demux_18_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y,
    output logic             v,
    output logic             free
);

    // A same-cycle ack frees the slot, so a new load can follow without a bubble.
    assign free = !v || ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
            v <= 1'b0;
        end else if (load) begin
            y <= d;
            v <= 1'b1;
        end else if (ack) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_18.sv
// Registered 1-to-8 demux: one word per cycle into eight handshaked holding slots,
// targeted by an explicit select or by an in-order round-robin pointer.
module demux_18
    import demux_18_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       s,
    input  logic             auto,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [7:0]       v,
    input  logic [7:0]       ack,
    output logic [2:0]       ptr
);

    logic [SEL_W-1:0]              ptr_q;
    logic [SEL_W-1:0]              tgt;
    logic                          accept;
    logic [DEMUX_N-1:0]            load;
    logic [DEMUX_N-1:0]            free;
    logic [DEMUX_N-1:0]            v_q;
    logic [DEMUX_N-1:0][WIDTH-1:0] y_q;

    // Target is re-evaluated every cycle; a stalled producer is not locked to a slot.
    assign tgt      = (mode_e'(auto) == MODE_AUTO) ? ptr_q : s;
    assign in_ready = free[tgt];
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < DEMUX_N; i++) begin : g_slot
        assign load[i] = accept && (tgt == SEL_W'(i));

        demux_18_slot #(.WIDTH(WIDTH)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .load (load[i]),
            .ack  (ack[i]),
            .d    (d),
            .y    (y_q[i]),
            .v    (v_q[i]),
            .free (free[i])
        );
    end

    // Pointer waits on a full slot rather than skipping it, keeping distribution in order.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else if (accept && mode_e'(auto) == MODE_AUTO)
            ptr_q <= ptr_q + SEL_W'(1);
    end

    assign v   = v_q;
    assign ptr = ptr_q;
    assign y0  = y_q[0];
    assign y1  = y_q[1];
    assign y2  = y_q[2];
    assign y3  = y_q[3];
    assign y4  = y_q[4];
    assign y5  = y_q[5];
    assign y6  = y_q[6];
    assign y7  = y_q[7];

endmodule

// File: tb/tb_demux_18.sv
// Bench for demux_18: directed vector table plus randomized traffic against a slot-level model.
module tb_demux_18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d = '0;
    logic [2:0]  s = '0;
    logic        auto = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [7:0]  v;
    logic [7:0]  ack = '0;
    logic [2:0]  ptr;
    logic [15:0] yv [8];

    int checks = 0;
    int errors = 0;

    // Reference state: one word and one full flag per channel, plus the pointer.
    logic [15:0] my [8];
    bit   [7:0]  mv;
    int          mp;
    bit          minit = 1'b0;

    typedef struct {
        bit        r;
        bit        a;
        bit [2:0]  sel;
        bit [15:0] dd;
        bit        iv;
        bit [7:0]  ak;
        bit        rdy;
        bit [7:0]  ev;
        bit [2:0]  ep;
        int        ch;
        bit [15:0] ey;
    } vec_t;

    vec_t vq[$];

    demux_18 #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .d(d), .s(s), .auto(auto),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .v(v), .ack(ack), .ptr(ptr)
    );

    always #5 clk = ~clk;

    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;
    assign yv[4] = y4;
    assign yv[5] = y5;
    assign yv[6] = y6;
    assign yv[7] = y7;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit r, bit a, bit [2:0] sel, bit [15:0] dd, bit iv, bit [7:0] ak,
                                bit rdy, bit [7:0] ev, bit [2:0] ep, int ch, bit [15:0] ey);
        vec_t x;
        x.r = r; x.a = a; x.sel = sel; x.dd = dd; x.iv = iv; x.ak = ak;
        x.rdy = rdy; x.ev = ev; x.ep = ep; x.ch = ch; x.ey = ey;
        return x;
    endfunction

    // Drive one cycle, check in_ready against the model, clock, then check all state.
    task automatic drive(input bit r, input bit a, input bit [2:0] sel, input bit [15:0] dd,
                         input bit iv, input bit [7:0] ak, output bit rdy_got);
        int  t;
        bit  mrdy;
        rst = r; auto = a; s = sel; d = dd; in_valid = iv; ack = ak;
        #1;
        t = a ? mp : int'(sel);
        mrdy = !mv[t] || ak[t];
        rdy_got = in_ready;
        if (minit) chk("in_ready", {31'b0, in_ready}, {31'b0, mrdy});
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 8; i++) my[i] = '0;
            mv = '0;
            mp = 0;
            minit = 1'b1;
        end else begin
            mv = mv & ~ak;
            if (iv && mrdy) begin
                my[t] = dd;
                mv[t] = 1'b1;
                if (a) mp = (mp + 1) % 8;
            end
        end
        if (minit) begin
            chk("v", {24'b0, v}, {24'b0, mv});
            chk("ptr", {29'b0, ptr}, mp);
            for (int i = 0; i < 8; i++)
                chk($sformatf("y%0d", i), {16'b0, yv[i]}, {16'b0, my[i]});
        end
    endtask

    initial begin
        bit rg;

        // Reset state.
        drive(1, 0, 0, 16'h0000, 0, 8'h00, rg);
        drive(1, 0, 0, 16'h0000, 0, 8'h00, rg);
        chk("reset_v", {24'b0, v}, 0);
        chk("reset_ptr", {29'b0, ptr}, 0);
        chk("reset_y2", {16'b0, y2}, 0);

        // Manual load, stall, same-cycle ack+reload, drain.
        vq.push_back(mk(0,0,2,16'h00AA,1,8'h00, 1,8'h04,0,2,16'h00AA));
        vq.push_back(mk(0,0,2,16'h00BB,1,8'h00, 0,8'h04,0,2,16'h00AA));
        vq.push_back(mk(0,0,2,16'h00BB,1,8'h04, 1,8'h04,0,2,16'h00BB));
        vq.push_back(mk(0,0,2,16'h0000,0,8'h04, 1,8'h00,0,2,16'h00BB));
        // Auto mode: eight back-to-back words with everything acked.
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(0,1,0,16'h0010 + 16'(i),1,8'hFF, 1,8'h01 << i,3'((i+1)%8),i,16'h0010 + 16'(i)));
        // Slot 0 full under auto: pointer waits, then a single ack lets it through.
        vq.push_back(mk(0,0,0,16'h0020,1,8'h80, 1,8'h01,0,0,16'h0020));
        vq.push_back(mk(0,1,0,16'h0021,1,8'h00, 0,8'h01,0,0,16'h0020));
        vq.push_back(mk(0,1,0,16'h0021,1,8'h01, 1,8'h01,1,0,16'h0021));
        vq.push_back(mk(0,1,0,16'h0000,0,8'h01, 1,8'h00,1,0,16'h0021));
        // Channels 1,4,7 loaded then acked together; ack on empty channel ignored.
        vq.push_back(mk(0,0,1,16'h0041,1,8'h00, 1,8'h02,1,1,16'h0041));
        vq.push_back(mk(0,0,4,16'h0044,1,8'h00, 1,8'h12,1,4,16'h0044));
        vq.push_back(mk(0,0,7,16'h0047,1,8'h00, 1,8'h92,1,7,16'h0047));
        vq.push_back(mk(0,0,0,16'h0000,0,8'h92, 1,8'h00,1,7,16'h0047));
        vq.push_back(mk(0,0,0,16'h0000,0,8'h20, 1,8'h00,1,1,16'h0041));
        // Reset during an offer discards held words and the offered word.
        vq.push_back(mk(0,0,0,16'h0050,1,8'h00, 1,8'h01,1,0,16'h0050));
        vq.push_back(mk(0,0,6,16'h0056,1,8'h00, 1,8'h41,1,6,16'h0056));
        vq.push_back(mk(1,0,3,16'h0099,1,8'h00, 1,8'h00,0,6,16'h0000));
        vq.push_back(mk(0,0,3,16'h0000,0,8'h00, 1,8'h00,0,3,16'h0000));

        foreach (vq[k]) begin
            drive(vq[k].r, vq[k].a, vq[k].sel, vq[k].dd, vq[k].iv, vq[k].ak, rg);
            chk($sformatf("vec%0d_rdy", k), {31'b0, rg}, {31'b0, vq[k].rdy});
            chk($sformatf("vec%0d_v", k), {24'b0, v}, {24'b0, vq[k].ev});
            chk($sformatf("vec%0d_ptr", k), {29'b0, ptr}, {29'b0, vq[k].ep});
            chk($sformatf("vec%0d_y%0d", k, vq[k].ch), {16'b0, yv[vq[k].ch]}, {16'b0, vq[k].ey});
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 63) == 0, 1'($urandom), 3'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, 8'($urandom & $urandom), rg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_18.md
Name: demux_18

Overview:
- Registered 1-to-8 demultiplexer: the distribution counterpart of the 8:1 mux datapath (16-bit words, 3-bit select).
- Routes one input word per cycle into one of eight output holding slots, each with its own valid/ack handshake.
- Target slot comes from the explicit select s (manual mode) or an internal round-robin pointer (auto mode).
- Sits between a single word producer and eight independent consumers.

Parameters:
- WIDTH, 16, data width of d and of each y0..y7.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- d  input  WIDTH  input data word.
- s  input  3  target channel in manual mode; ignored in auto mode.
- auto  input  1  1 = round-robin pointer selects the target; 0 = s selects it.
- in_valid  input  1  producer offers d this cycle.
- in_ready  output  1  target slot can accept this cycle.
- y0..y7  output  WIDTH each  holding registers of channels 0..7.
- v  output  8  v[i] = y_i holds an unacknowledged word.
- ack  input  8  ack[i] = consumer i takes y_i this cycle.
- ptr  output  3  current round-robin pointer, for debug and verification.

Behaviour:
- Reset (rst=1 at a clk edge): y0..y7=0, v=8'h00, ptr=0. in_ready is then 1 (combinational from state). rst overrides all other inputs in that cycle. Reset mid-operation discards all held words without any ack.
- Target t = auto ? ptr : s. t is re-evaluated every cycle; a stalled producer may change s and is not locked to any slot.
- in_ready = !v[t] | ack[t] (combinational). A same-cycle ack frees the slot.
- Accept = in_valid & in_ready. On accept: y_t <= d and v[t] <= 1 at the next edge. Latency is 1 cycle from accept to v[t]=1 and y_t valid.
- Ack: v[i] & ack[i] & !(accept to i) clears v[i] at the next edge. y_i keeps its last value; it is not cleared.
- Accept and ack on the same channel in the same cycle: v[t] stays 1 and y_t takes the new d. No bubble.
- ack[i] with v[i]=0 is ignored.
- Acks on several channels in one cycle are all honoured independently.
- in_valid with in_ready=0: no state change. The producer must hold d.
- ptr increments mod 8 only on an accept while auto=1. It wraps from 7 to 0. ptr is frozen while auto=0 and resumes from its held value when auto returns to 1.
- Auto mode does not skip full slots. The pointer waits on slot ptr until that slot is acked, which gives strict in-order distribution.
- Every output is registered except in_ready.

Decomposition:
- Shared package holds DEMUX_N=8, SEL_W=3, and the mode encodings MODE_MANUAL=0 and MODE_AUTO=1.
- One natural sub-module, demux_slot: a single WIDTH-bit holding register plus its valid flag.
  - Inputs: load, ack, d.
  - Outputs: y, v, free.
  - The top level instantiates eight of them and contains the target decode, the in_ready mux and the round-robin pointer.

Test Plan:
- Reset, then manual mode with s=3'b010, d=16'h00AA, in_valid=1 for one cycle -> next cycle v=8'h04, y2=16'h00AA, all other y=0. in_ready for s=2 drops to 0.
- Slot 2 still full, then in_valid=1, d=16'h00BB, s=2, ack=0 -> in_ready=0 and y2 stays 16'h00AA. Then ack[2]=1 with the same offer -> accept; v[2] stays 1 and y2=16'h00BB the next cycle.
- Auto mode with eight back-to-back words d=16'h0010..16'h0017 and ack=8'hFF every cycle -> each yi receives 16'h0010+i in order and ptr walks 0..7 then wraps to 0. in_ready stays 1 throughout.
- Auto mode with slot 0 full and ack=0 -> in_ready=0 and ptr stays 0 despite in_valid=1. A single ack[0] pulse -> accept that cycle and ptr=1 next cycle.
- Channels 1, 4, 7 loaded, then ack=8'h92 in one cycle -> v=8'h00 next cycle. y1, y4, y7 keep their data. ack on empty channel 5 -> no change.
- Load channels 0 and 6, then assert rst during an in_valid offer -> next cycle y all 0, v=0, ptr=0, and the offered word is not stored.
